// File: rtl/l2_tgen_master_if.sv
// Crossbar master-port bundle used by l2_tgen_master: request/grant channel plus response channel.
interface l2_tgen_master_if #(
    parameter int ADDR_IN_WIDTH = 13,
    parameter int DATA_WIDTH    = 32,
    parameter int BE_WIDTH      = DATA_WIDTH / 8
);
    logic                     data_req_o;
    logic [ADDR_IN_WIDTH-1:0] data_add_o;
    logic                     data_wen_o;
    logic [DATA_WIDTH-1:0]    data_wdata_o;
    logic [BE_WIDTH-1:0]      data_be_o;
    logic                     data_gnt_i;
    logic                     data_r_valid_i;
    logic [DATA_WIDTH-1:0]    data_r_rdata_i;

    modport master (
        output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
        input  data_gnt_i, data_r_valid_i, data_r_rdata_i
    );

    modport slave (
        input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
        output data_gnt_i, data_r_valid_i, data_r_rdata_i
    );
endinterface

// File: rtl/l2_tgen_master.sv
// L2 traffic generator: writes NUM_TRANS seeded words, reads them back and counts mismatches.
// Optional response watchdog enabled by defining L2_TGEN_TIMEOUT_EN.
module l2_tgen_master #(
    parameter int ADDR_IN_WIDTH = 13,
    parameter int DATA_WIDTH    = 32,
    parameter int BE_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_TRANS     = 16,
    parameter int TIMEOUT       = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [ADDR_IN_WIDTH-1:0] base_addr_i,
    input  logic [DATA_WIDTH-1:0]    seed_i,
    l2_tgen_master_if.master         bus,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [8:0]               err_cnt_o,
    output logic [ADDR_IN_WIDTH-1:0] first_err_addr_o,
    output logic                     timeout_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_RESP = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    // Eight index bits cover the full 1..256 range of NUM_TRANS.
    localparam int              IDX_W    = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRANS - 1);
    localparam int              TO_W     = $clog2(TIMEOUT + 1);

`ifdef L2_TGEN_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic [2:0]               state;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         idx_nxt;
    logic [ADDR_IN_WIDTH-1:0] base_q;
    logic [ADDR_IN_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0]    seed_q;
    logic [DATA_WIDTH-1:0]    exp_data;
    logic [TO_W-1:0]          wait_cnt;
    logic                     start_ok;
    logic                     in_req;
    logic                     in_resp;
    logic                     wait_evt;
    logic                     wait_expired;

    // Word i of a pass: (seed + i) XOR i[7:0] replicated across the data word.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [DATA_WIDTH-1:0] seed,
                                                      input logic [IDX_W-1:0]      i);
        logic [DATA_WIDTH-1:0] rep;
        rep = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            rep[b] = i[b % 8];
        end
        return (seed + DATA_WIDTH'(i)) ^ rep;
    endfunction

    assign start_ok     = start_i && (state == S_IDLE || state == S_DONE);
    assign in_req       = (state == S_WR_REQ) || (state == S_RD_REQ);
    assign in_resp      = (state == S_WR_RESP) || (state == S_RD_RESP);
    // In a request state only the grant counts, so a coincident r_valid is ignored.
    assign wait_evt     = (in_req && bus.data_gnt_i) || (in_resp && bus.data_r_valid_i);
    assign wait_expired = TIMEOUT_EN && (wait_cnt == TO_W'(TIMEOUT - 1));
    assign idx_nxt      = idx + 1'b1;
    assign addr_nxt     = base_q + ADDR_IN_WIDTH'(idx_nxt);
    assign exp_data     = pattern(seed_q, idx);

    assign busy_o = (state != S_IDLE) && (state != S_DONE);
    assign done_o = (state == S_DONE);

    // Cycles spent waiting in the current request/response state.
    always_ff @(posedge clk) begin
        if (!rst_n || !(in_req || in_resp) || wait_evt) begin
            wait_cnt <= '0;
        end else if (!wait_expired) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // NOTE: rst_n is sampled on the clock edge only and is deliberately absent from the
    // sensitivity list, so reset is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments throughout, so every register in this block
            // updates from values seen before the edge regardless of statement order.
            state            <= S_IDLE;
            idx              <= '0;
            base_q           <= '0;
            seed_q           <= '0;
            bus.data_req_o   <= 1'b0;
            bus.data_add_o   <= '0;
            bus.data_wen_o   <= 1'b0;
            bus.data_wdata_o <= '0;
            bus.data_be_o    <= '0;
            err_o            <= 1'b0;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            timeout_o        <= 1'b0;
        end else if ((in_req || in_resp) && !wait_evt && wait_expired) begin
            timeout_o      <= 1'b1;
            err_o          <= 1'b1;
            bus.data_req_o <= 1'b0;
            state          <= S_DONE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        base_q           <= base_addr_i;
                        seed_q           <= seed_i;
                        idx              <= '0;
                        bus.data_req_o   <= 1'b1;
                        bus.data_add_o   <= base_addr_i;
                        bus.data_wen_o   <= 1'b1;
                        bus.data_wdata_o <= pattern(seed_i, '0);
                        bus.data_be_o    <= '1;
                        err_o            <= 1'b0;
                        err_cnt_o        <= '0;
                        first_err_addr_o <= '0;
                        timeout_o        <= 1'b0;
                        state            <= S_WR_REQ;
                    end
                end

                S_WR_REQ, S_RD_REQ: begin
                    if (bus.data_gnt_i) begin
                        bus.data_req_o <= 1'b0;
                        state          <= (state == S_WR_REQ) ? S_WR_RESP : S_RD_RESP;
                    end
                end

                S_WR_RESP: begin
                    if (bus.data_r_valid_i) begin
                        bus.data_req_o <= 1'b1;
                        if (idx == LAST_IDX) begin
                            // Write phase finished: replay the same addresses as loads.
                            idx              <= '0;
                            bus.data_add_o   <= base_q;
                            bus.data_wen_o   <= 1'b0;
                            bus.data_wdata_o <= '0;
                            bus.data_be_o    <= '0;
                            state            <= S_RD_REQ;
                        end else begin
                            idx              <= idx_nxt;
                            bus.data_add_o   <= addr_nxt;
                            bus.data_wdata_o <= pattern(seed_q, idx_nxt);
                            state            <= S_WR_REQ;
                        end
                    end
                end

                S_RD_RESP: begin
                    if (bus.data_r_valid_i) begin
                        if (bus.data_r_rdata_i != exp_data) begin
                            err_o <= 1'b1;
                            if (err_cnt_o != 9'd511) begin
                                err_cnt_o <= err_cnt_o + 1'b1;
                            end
                            if (err_cnt_o == '0) begin
                                first_err_addr_o <= bus.data_add_o;
                            end
                        end
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            idx            <= idx_nxt;
                            bus.data_add_o <= addr_nxt;
                            bus.data_req_o <= 1'b1;
                            state          <= S_RD_REQ;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_tgen_master.sv
// Self-checking bench for l2_tgen_master: directed vector table, hand sequences for reset,
// ignored start/response and stall corners, then randomized passes against a behavioural model.
module tb_l2_tgen_master;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int NT = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [DW-1:0] seed_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [8:0]    err_cnt_o;
    logic [AW-1:0] first_err_addr_o;
    logic          timeout_o;

    l2_tgen_master_if #(.ADDR_IN_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

    l2_tgen_master #(
        .ADDR_IN_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .NUM_TRANS(NT), .TIMEOUT(TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start_i),
        .base_addr_i      (base_addr_i),
        .seed_i           (seed_i),
        .bus              (bus.master),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .err_cnt_o        (err_cnt_o),
        .first_err_addr_o (first_err_addr_o),
        .timeout_o        (timeout_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } txn_t;

    // Transaction n of a pass: first NT are stores, the next NT the matching loads.
    function automatic txn_t model_txn(input logic [AW-1:0] base, input logic [DW-1:0] seed,
                                       input int n);
        txn_t     t;
        int       i;
        logic [7:0] i8;
        i    = n % NT;
        i8   = i[7:0];
        t.addr = base + AW'(i);
        if (n < NT) begin
            t.wen   = 1'b1;
            t.wdata = (seed + DW'(i)) ^ ({24'd0, i8} * 32'h0101_0101);
            t.be    = '1;
        end else begin
            t.wen   = 1'b0;
            t.wdata = '0;
            t.be    = '0;
        end
        return t;
    endfunction

    // Slave (memory) model state and knobs.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            slave_en   = 1'b0;
    bit            rand_mode  = 1'b0;
    bit            corrupt_en = 1'b0;
    bit            no_resp    = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    int            hold_tx   = -1;
    int            hold_cyc  = 0;
    logic [AW-1:0] cur_base;
    logic [DW-1:0] cur_seed;
    int            tx_num;
    int            hold_left;
    bit            hold_active;
    int            resp_wait;
    logic [DW-1:0] resp_data;
    bit            just_gnt;
    bit            just_resp;

    initial begin
        bus.data_gnt_i     = 1'b0;
        bus.data_r_valid_i = 1'b0;
        bus.data_r_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (slave_en) begin
                bus.data_gnt_i     = 1'b0;
                bus.data_r_valid_i = 1'b0;
                if (just_gnt) begin
                    just_gnt = 1'b0;
                    check("req_drop_after_gnt", 64'(bus.data_req_o), 64'd0);
                end
                if (just_resp) begin
                    just_resp = 1'b0;
                    if (tx_num < 2 * NT) check("req_after_rvalid", 64'(bus.data_req_o), 64'd1);
                end
                if (resp_wait > 0) begin
                    resp_wait--;
                    if (resp_wait == 0) begin
                        bus.data_r_valid_i = 1'b1;
                        bus.data_r_rdata_i = resp_data;
                        just_resp          = 1'b1;
                    end
                end else if (bus.data_req_o) begin
                    check("req_fields",
                          64'({bus.data_add_o, bus.data_wen_o, bus.data_wdata_o, bus.data_be_o}),
                          64'(model_txn(cur_base, cur_seed, tx_num)));
                    if (!hold_active) begin
                        hold_active = 1'b1;
                        hold_left   = (tx_num == hold_tx) ? hold_cyc :
                                      (rand_mode ? int'($urandom_range(0, 3)) : 0);
                    end
                    if (hold_left == 0) begin
                        bus.data_gnt_i = 1'b1;
                        if (rand_mode && $urandom_range(0, 1) == 1) begin
                            bus.data_r_valid_i = 1'b1;
                            bus.data_r_rdata_i = $urandom;
                        end
                        if (bus.data_wen_o) begin
                            mem[bus.data_add_o] = bus.data_wdata_o;
                            resp_data = '0;
                        end else begin
                            resp_data = mem[bus.data_add_o] ^
                                ((corrupt_en && bus.data_add_o == corrupt_addr) ? 32'h0000_0100 : 32'h0);
                        end
                        resp_wait   = no_resp ? 0 : (rand_mode ? int'($urandom_range(1, 3)) : 1);
                        hold_active = 1'b0;
                        just_gnt    = 1'b1;
                        tx_num++;
                    end else begin
                        hold_left--;
                    end
                end
            end
        end
    end

    // Called just after a negedge; returns one negedge later with the request raised.
    task automatic start_pass(input logic [AW-1:0] base, input logic [DW-1:0] seed);
        cur_base    = base;
        cur_seed    = seed;
        tx_num      = 0;
        hold_active = 1'b0;
        resp_wait   = 0;
        just_gnt    = 1'b0;
        just_resp   = 1'b0;
        check("req_low_before_start", 64'(bus.data_req_o), 64'd0);
        base_addr_i = base;
        seed_i      = seed;
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("start_accept", 64'({bus.data_req_o, busy_o, done_o, err_o, err_cnt_o, timeout_o}),
              64'({1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0}));
    endtask

    task automatic run_pass(input logic [AW-1:0] base, input logic [DW-1:0] seed, input int mid_at);
        int            exp_cnt;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] a;
        exp_cnt   = 0;
        exp_first = '0;
        for (int i = 0; i < NT; i++) begin
            a = base + AW'(i);
            if (corrupt_en && a == corrupt_addr) begin
                if (exp_cnt == 0) exp_first = a;
                exp_cnt++;
            end
        end
        start_pass(base, seed);
        for (int c = 0; c < 400; c++) begin
            if (done_o) break;
            start_i = (c == mid_at);
            if (c == mid_at) begin
                base_addr_i = base ^ 13'h0aaa;
                seed_i      = ~seed;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        check("pass_done", 64'({done_o, busy_o, bus.data_req_o}), 64'({1'b1, 1'b0, 1'b0}));
        check("grant_count", 64'(tx_num), 64'(2 * NT));
        check("err_status", 64'({err_o, err_cnt_o, timeout_o}),
              64'({exp_cnt != 0, 9'(exp_cnt), 1'b0}));
        check("first_err_addr", 64'(first_err_addr_o), 64'(exp_first));
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [DW-1:0] seed;
        int            hold_tx;
        int            hold_cyc;
        bit            corrupt_en;
        logic [AW-1:0] corrupt_addr;
        bit            exp_err;
        int            exp_cnt;
        logic [AW-1:0] exp_first;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{13'h00fe, 32'hdea0_bee0, -1, 0, 1'b0, 13'h0000, 1'b0, 0, 13'h0000};
        vecs[1] = '{13'h00fe, 32'hdea0_bee0,  2, 5, 1'b0, 13'h0000, 1'b0, 0, 13'h0000};
        vecs[2] = '{13'h00fe, 32'hdea0_bee0, -1, 0, 1'b1, 13'h0100, 1'b1, 1, 13'h0100};
        vecs[3] = '{13'h1ffe, 32'h1234_5678, -1, 0, 1'b0, 13'h0000, 1'b0, 0, 13'h0000};
        vecs[4] = '{13'h0040, 32'hffff_fffe,  0, 3, 1'b1, 13'h0044, 1'b0, 0, 13'h0000};

        // NOTE: inputs are driven just after the falling edge so they are stable at the
        // rising edge the DUT samples.
        rst_n       = 1'b0;
        start_i     = 1'b1;
        base_addr_i = 13'h1abc;
        seed_i      = 32'hcafe_f00d;
        repeat (3) begin
            @(negedge clk);
            check("rst_bus_zero", 64'({bus.data_req_o, bus.data_add_o, bus.data_wen_o,
                                       bus.data_wdata_o, bus.data_be_o}), 64'd0);
            check("rst_status_zero", 64'({busy_o, done_o, err_o, err_cnt_o, first_err_addr_o,
                                          timeout_o}), 64'd0);
        end
        rst_n   = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 64'({busy_o, done_o, bus.data_req_o}), 64'd0);

        slave_en = 1'b1;
        for (int v = 0; v < 5; v++) begin
            hold_tx      = vecs[v].hold_tx;
            hold_cyc     = vecs[v].hold_cyc;
            corrupt_en   = vecs[v].corrupt_en;
            corrupt_addr = vecs[v].corrupt_addr;
            run_pass(vecs[v].base, vecs[v].seed, -1);
            check("vec_err", 64'({err_o, err_cnt_o}), 64'({vecs[v].exp_err, 9'(vecs[v].exp_cnt)}));
            check("vec_first", 64'(first_err_addr_o), 64'(vecs[v].exp_first));
        end

        // Start pulse while busy must be ignored.
        hold_tx    = -1;
        corrupt_en = 1'b0;
        run_pass(13'h0300, 32'h0bad_beef, 3);

        // Reset in the middle of a store, then a stray response and grant in IDLE.
        no_resp = 1'b1;
        start_pass(13'h0500, 32'h5555_aaaa);
        repeat (2) @(negedge clk);
        check("mid_wait_resp", 64'({busy_o, bus.data_req_o}), 64'({1'b1, 1'b0}));
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_bus_zero", 64'({bus.data_req_o, bus.data_add_o, bus.data_wen_o,
                                       bus.data_wdata_o, bus.data_be_o}), 64'd0);
        check("mid_rst_status_zero", 64'({busy_o, done_o, err_o, err_cnt_o, first_err_addr_o,
                                          timeout_o}), 64'd0);
        slave_en           = 1'b0;
        rst_n              = 1'b1;
        bus.data_r_valid_i = 1'b1;
        bus.data_gnt_i     = 1'b1;
        bus.data_r_rdata_i = 32'h1357_9bdf;
        repeat (3) @(negedge clk);
        check("stray_resp_ignored", 64'({busy_o, done_o, err_o, bus.data_req_o}), 64'd0);
        bus.data_r_valid_i = 1'b0;
        bus.data_gnt_i     = 1'b0;
        @(negedge clk);

        // No response after the first grant.
        slave_en = 1'b1;
        start_pass(13'h0700, 32'h0000_0001);
        repeat (100) @(negedge clk);
`ifdef L2_TGEN_TIMEOUT_EN
        check("timeout_done", 64'({timeout_o, err_o, done_o, busy_o, bus.data_req_o}),
              64'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0}));
`else
        check("hang_in_wr_resp", 64'({timeout_o, err_o, done_o, busy_o, bus.data_req_o}),
              64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
`endif
        check("hang_single_grant", 64'(tx_num), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        no_resp = 1'b0;
        @(negedge clk);

        // Randomized passes with random stalls, latencies and corruption.
        rand_mode = 1'b1;
        for (int r = 0; r < 24; r++) begin
            logic [AW-1:0] b;
            b            = AW'($urandom);
            hold_tx      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * NT - 1)) : -1;
            hold_cyc     = int'($urandom_range(1, 6));
            corrupt_en   = ($urandom_range(0, 1) == 1);
            corrupt_addr = b + AW'($urandom_range(0, 5));
            run_pass(b, $urandom, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
